fxp_seq_divider: RTL and testbench
==================================

Name: fxp_seq_divider

Overview:
- Multi-cycle signed fixed-point divider/reciprocal unit. Uses the codebase's sign-magnitude Q-format: bit N-1 is the sign, the low Q bits are fraction.
- Replaces the combinational Newton-Raphson reciprocal chain for equation datapaths that tolerate latency.
- Restoring long division, one quotient bit per cycle. Results are exact (truncated), not approximate.
- Valid/ready handshakes on both sides; saturation and divide-by-zero flags.

Parameters:
- N, 32, total word width including sign bit (N >= 4)
- Q, 16, fractional bits (1 <= Q <= N-2)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  unit can accept operands
- op_recip  input  1  0: c = a/b; 1: c = 1.0/b (a ignored)
- a  input  N  dividend, sign-magnitude Q-format
- b  input  N  divisor, sign-magnitude Q-format
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- c  output  N  quotient, sign-magnitude Q-format
- div_by_zero  output  1  divisor magnitude was zero (valid with out_valid)
- overflow  output  1  quotient magnitude saturated (valid with out_valid)
- busy  output  1  high in CALC or DONE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE; in_ready=1; out_valid=0; c=0; div_by_zero=0; overflow=0; busy=0.
- Reset has priority over all other inputs. Reset mid-CALC or mid-DONE aborts the operation and discards the result.
- FSM states: IDLE, CALC, DONE. One operation in flight at a time.
- in_ready = (state==IDLE).
- Acceptance: a transfer occurs on an edge where in_valid && in_ready.
  - The unit latches: ma = op_recip ? (1<<Q) : a[N-2:0]; sa = op_recip ? 0 : a[N-1]; mb = b[N-2:0]; sb = b[N-1].
  - Operands are not sampled again until the next acceptance.
- IDLE transitions on acceptance:
  - mb==0: go to DONE. c = {1'b0 if ma==0 else sa^sb, all-ones magnitude}; div_by_zero=1; overflow=0.
  - mb!=0: go to CALC. Load dividend D = ma<<Q (N-1+Q bits), remainder R=0, counter K=N-1+Q.
- CALC, each cycle:
  - R' = {R, next MSB of D}.
  - If R' >= mb: subtract mb and shift 1 into quotient; else shift 0.
  - K decrements. R is N bits wide; quotient register is N-1+Q bits.
  - On the cycle K reaches 0, go to DONE.
- Result formation on entering DONE from CALC:
  - If any of the top Q quotient bits is set: magnitude = 2^(N-1)-1, overflow=1.
  - Otherwise: magnitude = quotient[N-2:0], overflow=0.
  - Sign = sa^sb, forced to 0 when magnitude==0 (no negative zero).
  - div_by_zero=0.
- Latency, counting the acceptance edge as edge 0:
  - Normal operation: out_valid rises after edge N+Q (edge 48 at defaults).
  - Divide-by-zero: out_valid rises after edge 1.
- DONE:
  - out_valid=1.
  - c, div_by_zero and overflow are held stable until an edge with out_ready=1. That edge returns the FSM to IDLE.
  - in_ready is 0 throughout DONE. No same-cycle accept on the pop edge; the next accept is possible on the following edge at the earliest.
  - Outputs keep their last values in IDLE; out_valid=0.
- Sign bit of a zero-magnitude b is ignored for the divide-by-zero decision.
- a with zero magnitude and nonzero b gives c=0 after full latency, both flags 0.
- in_valid or operand changes during CALC/DONE have no effect.

Test Plan:
- Basic divide, N=32/Q=16: a=0x00060000, b=0x00020000, op_recip=0 -> c=0x00030000, flags 0, out_valid exactly 48 edges after accept.
- Signed truncation: a=0x80010000 (-1.0), b=0x00030000 (3.0) -> c=0x80005555; a=0x80000000, b=0x00030000 -> c=0x00000000 (sign cleared).
- Reciprocal mode: op_recip=1, a=0x12345678, b=0x80040000 (-4.0) -> c=0x80004000.
- Divide-by-zero and overflow:
  - a=0x00010000, b=0x80000000 -> c=0xFFFFFFFF, div_by_zero=1, out_valid 1 edge after accept.
  - a=0x7FFF0000, b=0x00000001 -> c=0x7FFFFFFF, overflow=1.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> c/flags stable, in_ready=0, in_valid ignored; out_ready=1 for one edge -> IDLE, in_ready=1 on the next cycle.
- Reset mid-CALC: assert reset 10 cycles after accept -> next cycle out_valid=0, in_ready=1, c=0; a following 6.0/2.0 operation completes correctly.

Source files
------------

// File: rtl/fxp_seq_divider.sv
// Multi-cycle signed (sign-magnitude) fixed-point divider / reciprocal unit.
// Restoring long division produces one truncated quotient bit per clock.
module fxp_seq_divider #(
  parameter int N = 32,
  parameter int Q = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_recip,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         div_by_zero,
  output logic         overflow,
  output logic         busy
);

  localparam int W  = N - 1 + Q;
  localparam int KW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [W-1:0]    qd_q;
  logic [N-1:0]    rem_q;
  logic [KW-1:0]   k_q;
  logic [N-2:0]    mb_q;
  logic            sign_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [N-1:0]    c_q;
  logic            dbz_q;
  logic            ovf_q;
  logic            busy_q;

  logic [N-2:0]    ma_s;
  logic            sa_s;
  logic            accept_s;
  logic [N-1:0]    trial_s;
  logic [N-1:0]    rem_d;
  logic [W-1:0]    qd_d;
  logic            qbit_s;
  logic            ovf_s;
  logic [N-2:0]    mag_s;

  // Operand magnitude/sign selection for the acceptance edge.
  always_comb begin
    ma_s     = {(N-1){1'b0}};
    sa_s     = 1'b0;
    accept_s = in_valid & in_ready_q;
    if (op_recip) begin
      ma_s = {{(N-2){1'b0}}, 1'b1} << Q;
      sa_s = 1'b0;
    end else begin
      ma_s = a[N-2:0];
      sa_s = a[N-1];
    end
  end

  // qd_q shifts dividend bits out of the top while quotient bits enter at the bottom.
  always_comb begin
    trial_s = {rem_q[N-2:0], qd_q[W-1]};
    rem_d   = trial_s;
    qbit_s  = 1'b0;
    if (trial_s >= {1'b0, mb_q}) begin
      rem_d  = trial_s - {1'b0, mb_q};
      qbit_s = 1'b1;
    end else begin
      rem_d  = trial_s;
      qbit_s = 1'b0;
    end
    qd_d  = {qd_q[W-2:0], qbit_s};
    ovf_s = |qd_d[W-1:N-1];
    if (ovf_s) begin
      mag_s = {(N-1){1'b1}};
    end else begin
      mag_s = qd_d[N-2:0];
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      qd_q        <= {W{1'b0}};
      rem_q       <= {N{1'b0}};
      k_q         <= {KW{1'b0}};
      mb_q        <= {(N-1){1'b0}};
      sign_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      c_q         <= {N{1'b0}};
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            mb_q       <= b[N-2:0];
            sign_q     <= sa_s ^ b[N-1];
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (b[N-2:0] == {(N-1){1'b0}}) begin
              state_q <= DONE;
              c_q     <= {(ma_s != {(N-1){1'b0}}) & (sa_s ^ b[N-1]), {(N-1){1'b1}}};
              dbz_q   <= 1'b1;
              ovf_q   <= 1'b0;
            end else begin
              state_q <= CALC;
              qd_q    <= {ma_s, {Q{1'b0}}};
              rem_q   <= {N{1'b0}};
              k_q     <= KW'(W);
            end
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          qd_q  <= qd_d;
          rem_q <= rem_d;
          k_q   <= k_q - {{(KW-1){1'b0}}, 1'b1};
          if (k_q == {{(KW-1){1'b0}}, 1'b1}) begin
            state_q <= DONE;
            c_q     <= {sign_q & (|mag_s), mag_s};
            dbz_q   <= 1'b0;
            ovf_q   <= ovf_s;
          end else begin
            state_q <= CALC;
          end
        end
        DONE: begin
          // Result registers settle on entry; out_valid follows one edge later.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign c           = c_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_fxp_seq_divider.sv
// Directed bench for fxp_seq_divider at N=32, Q=16 with hand-computed results.
module tb_fxp_seq_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        op_recip;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c;
  logic        div_by_zero;
  logic        overflow;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  fxp_seq_divider #(.N(32), .Q(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_recip(op_recip), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .c(c), .div_by_zero(div_by_zero),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Accept one operation, wait (bounded) for out_valid, capture, then pop.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic rv,
                        output logic [31:0] cr, output logic dz, output logic ov,
                        output int lat);
    in_valid = 1'b1; a = av; b = bv; op_recip = rv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    cr = c; dz = div_by_zero; ov = overflow;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests_run++;
    if ({in_ready, out_valid, div_by_zero, overflow, busy} !== 5'b10000 || c !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset: rdy/vld/dz/ov/busy=%b c=%h, want 10000 c=00000000",
               {in_ready, out_valid, div_by_zero, overflow, busy}, c);
    end
  endtask

  task automatic check_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                          input logic rv, input logic [31:0] ec, input logic edz,
                          input logic eov, input int elat);
    logic [31:0] cr; logic dz; logic ov; int lat;
    run_op(av, bv, rv, cr, dz, ov, lat);
    tests_run++;
    if (cr !== ec || dz !== edz || ov !== eov) begin
      tests_failed++;
      $display("FAIL %s: c=%h dz=%b ov=%b, want c=%h dz=%b ov=%b", name, cr, dz, ov, ec, edz, eov);
    end
    tests_run++;
    if (lat !== elat) begin
      tests_failed++;
      $display("FAIL %s_latency: got %0d edges, want %0d", name, lat, elat);
    end
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_pop: out_valid=%b in_ready=%b, want 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_basic();
    check_op("basic_6_div_2", 32'h0006_0000, 32'h0002_0000, 1'b0, 32'h0003_0000, 1'b0, 1'b0, 48);
  endtask

  task automatic test_signed();
    check_op("neg1_div_3", 32'h8001_0000, 32'h0003_0000, 1'b0, 32'h8000_5555, 1'b0, 1'b0, 48);
    check_op("negzero_div_3", 32'h8000_0000, 32'h0003_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 48);
  endtask

  task automatic test_recip();
    check_op("recip_neg4", 32'h1234_5678, 32'h8004_0000, 1'b1, 32'h8000_4000, 1'b0, 1'b0, 48);
  endtask

  task automatic test_div_zero();
    check_op("div0_neg", 32'h0001_0000, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1);
    check_op("div0_zero_a", 32'h8000_0000, 32'h0000_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
  endtask

  task automatic test_overflow();
    check_op("overflow", 32'h7FFF_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 48);
  endtask

  task automatic test_backpressure();
    int n; logic stable;
    in_valid = 1'b1; a = 32'h0006_0000; b = 32'h0002_0000; op_recip = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    stable = out_valid;
    in_valid = 1'b1; a = 32'h0009_0000; b = 32'h0000_0000;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || c !== 32'h0003_0000 ||
          div_by_zero !== 1'b0 || overflow !== 1'b0) stable = 1'b0;
    end
    tests_run++;
    if (stable !== 1'b1) begin
      tests_failed++;
      $display("FAIL backpressure_hold: outputs changed, c=%h vld=%b rdy=%b, want c=00030000 vld=1 rdy=0",
               c, out_valid, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || c !== 32'h0003_0000) begin
      tests_failed++;
      $display("FAIL backpressure_pop: vld=%b rdy=%b busy=%b c=%h, want 0 1 0 00030000",
               out_valid, in_ready, busy, c);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_calc();
    in_valid = 1'b1; a = 32'h0006_0000; b = 32'h0002_0000; op_recip = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || c !== 32'h0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_calc: vld=%b rdy=%b busy=%b c=%h, want 0 1 0 00000000",
               out_valid, in_ready, busy, c);
    end
    check_op("after_reset_6_div_2", 32'h0006_0000, 32'h0002_0000, 1'b0, 32'h0003_0000, 1'b0, 1'b0, 48);
  endtask

  task automatic test_back_to_back();
    check_op("b2b_recip_half", 32'h0000_0000, 32'h0000_8000, 1'b1, 32'h0002_0000, 1'b0, 1'b0, 48);
    check_op("b2b_zero_a", 32'h0000_0000, 32'h8005_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 48);
    check_op("b2b_7_div_neg2", 32'h0007_0000, 32'h8002_0000, 1'b0, 32'h8003_8000, 1'b0, 1'b0, 48);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op_recip = 1'b0; a = 32'h0; b = 32'h0; out_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_signed();
    test_recip();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
